uart_tx_buffered: RTL
=====================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bit count; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, input buffer entries; power of two, at least 2.
REQ-007 clk  input  1  clock; all logic rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 s_valid  input  1  write request for s_data.
REQ-010 s_data  input  DATA_BITS  payload, LSB transmitted first.
REQ-011 s_ready  output  1  FIFO can accept a word this cycle.
REQ-012 tx_enable  input  1  permission to start a new frame.
REQ-013 serial_out  output  1  registered UART line; idle high.
REQ-014 busy  output  1  frame in progress.
REQ-015 tx_done  output  1  single-cycle pulse when a frame's last stop bit completes.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Bit period DIV = CLK_FREQ/BAUD_RATE, forced to 1 if the quotient is 0; every transmitted bit holds serial_out for exactly DIV clk cycles.
REQ-018 Frame order: start bit (0), DATA_BITS payload bits LSB first, parity bit if PARITY!=0, then STOP_BITS stop bits (1).
REQ-019 Parity bit: even mode = XOR of payload; odd mode = inverted XOR of payload.
REQ-020 Write accepted when s_valid && s_ready; s_ready = (fifo_level < FIFO_DEPTH), independent of a same-cycle pop.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-022 IDLE->START: when FIFO non-empty and tx_enable=1, head word popped; serial_out=0 from the next cycle.
REQ-023 START->DATA, DATA->PARITY/STOP, and PARITY->STOP transitions occur after DIV cycles; DATA advances through bit index 0..DATA_BITS-1.
REQ-024 STOP exit after STOP_BITS*DIV cycles: tx_done pulses for one cycle; goes directly to START if FIFO non-empty and tx_enable=1 (zero idle gap), otherwise to IDLE.
REQ-025 A word written into an empty FIFO is poppable no earlier than the following cycle.
REQ-026 tx_enable deasserted mid-frame: current frame completes unchanged; no new frame starts.
REQ-027 busy=1 in every state except IDLE; serial_out=1 in IDLE.
REQ-028 fifo_level increments on push, decrements on pop, and is unchanged on a simultaneous push and pop.
REQ-029 Write while full: ignored, no corruption, fifo_level unchanged.

Reset
REQ-030 rst asserted: serial_out=1, busy=0, tx_done=0, fifo_level=0, s_ready=1, FSM=IDLE, counters cleared, FIFO emptied.
REQ-031 rst mid-frame: line returns high immediately; the aborted frame is not resumed, and queued words are discarded.

Structure
REQ-032 Shared package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx state enumeration.
REQ-033 Sub-module uart_sync_fifo, parametrised width/depth, providing push/pop, full/empty, and level; the baud counter and FSM reside in uart_tx_buffered.
REQ-034 Illegal parameter values are rejected by an elaboration-time check.

Verification
REQ-035 DIV=4, 8N1, push 0xA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once at frame end.
REQ-036 PARITY=1, push 0x07 -> parity bit 1; PARITY=2, push 0x07 -> parity bit 0.
REQ-037 STOP_BITS=2, push 0x00 then 0xFF back-to-back -> two stop bits (8 cycles at DIV=4) high, then the next start bit follows with no gap.
REQ-038 FIFO_DEPTH=4, tx_enable=0, push 6 words -> s_ready low after 4 words, fifo_level=4; after tx_enable=1, exactly 4 frames are sent in order.
REQ-039 Assert rst during DATA bit 3 -> serial_out=1 and busy=0 asynchronously, fifo_level=0; no tx_done pulse.
REQ-040 Deassert tx_enable mid-frame with 2 words queued -> current frame completes; line stays idle and fifo_level=2 until re-enabled.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the buffered UART transmitter.
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity mode encodings for the PARITY parameter
//   tx_state_t                    : transmitter frame state
//   calc_div()                    : clocks per bit, never less than one
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // A baud rate above the clock rate would give a zero quotient; clamp so
  // every bit still lasts one clock.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    int q;
    q = clk_freq / baud_rate;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- single-clock FIFO with registered read data.
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data   : write request; ignored while full
//   pop, rd_data    : read request; ignored while empty. rd_data is loaded on
//                     the pop edge and then holds until the next pop.
//   full, empty     : occupancy flags
//   level           : number of stored words, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_reg;
  assign rd_data = rd_data_reg;

  // Storage carries no reset so it maps onto RAM; validity is tracked by
  // the pointers and level alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // A pop never targets the slot being written in the same cycle: a word is
  // only visible through level one cycle after its write, and a push while
  // full (the only way the pointers could coincide) is refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- UART transmitter fed from an input FIFO.
//   clk, rst    : clock, asynchronous active-high reset (aborts frame, empties FIFO)
//   s_valid     : write request for s_data
//   s_data      : payload, sent LSB first
//   s_ready     : FIFO has room this cycle
//   tx_enable   : permission to start a new frame (a running frame always completes)
//   serial_out  : registered line, idle high
//   busy        : a frame is in progress
//   tx_done     : one-cycle pulse after the last stop bit of a frame
//   fifo_level  : FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  input  logic                          tx_enable,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int STOP_LEN = STOP_BITS * DIV;
  localparam int CW       = $clog2(STOP_LEN + 1);
  localparam int BW       = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_buffered: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_buffered: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (CLK_FREQ < 1 || BAUD_RATE < 1) begin : g_bad_rate
      $error("uart_tx_buffered: CLK_FREQ and BAUD_RATE must be positive");
    end
  endgenerate

  tx_state_t            state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic                 serial_reg, serial_next;
  logic                 tx_done_reg, tx_done_next;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 can_start;
  logic                 bit_end;
  logic                 stop_end;
  logic                 parity_bit;
  logic [DATA_BITS-1:0] word;

  // The FIFO's registered read port only changes on a pop, and pops happen
  // only when a frame starts, so rd_data serves as the frame's data register.
  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_ready    = !fifo_full;
  assign can_start  = !fifo_empty && tx_enable;
  assign bit_end    = (cnt_reg == CW'(DIV - 1));
  assign stop_end   = (cnt_reg == CW'(STOP_LEN - 1));
  assign parity_bit = (PARITY == PAR_ODD) ? ~(^word) : (^word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      serial_reg  <= 1'b1;
      tx_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      serial_reg  <= serial_next;
      tx_done_reg <= tx_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    bit_idx_next = bit_idx_reg;
    tx_done_next = 1'b0;
    pop          = 1'b0;
    serial_next  = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (can_start) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // All stop bits are timed as one interval.
        if (stop_end) begin
          cnt_next     = '0;
          tx_done_next = 1'b1;
          if (can_start) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    // The line is registered, so it is computed from the state being entered.
    case (state_next)
      ST_START:  serial_next = 1'b0;
      ST_DATA:   serial_next = word[bit_idx_next];
      ST_PARITY: serial_next = parity_bit;
      default:   serial_next = 1'b1;
    endcase
  end

  assign serial_out = serial_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign tx_done    = tx_done_reg;

endmodule
